// File: rtl/mem_arbiter_if.sv
// Port bundle for mem_arbiter: two cpu request ports (A = fetch, B = data) and the shared memory port.
// The arbiter uses the slave modport; the cpu/memory side uses master.
interface mem_arbiter_if;
   logic        a_read;
   logic        a_write;
   logic [15:0] a_address;
   logic [15:0] a_wdata;
   logic        a_resp;
   logic [15:0] a_rdata;

   logic        b_read;
   logic        b_write;
   logic [15:0] b_address;
   logic [15:0] b_wdata;
   logic        b_resp;
   logic [15:0] b_rdata;

   logic        mem_read;
   logic        mem_write;
   logic [15:0] mem_address;
   logic [15:0] mem_wdata;
   logic        mem_resp;
   logic [15:0] mem_rdata;

   modport slave (
      input  a_read, a_write, a_address, a_wdata,
      output a_resp, a_rdata,
      input  b_read, b_write, b_address, b_wdata,
      output b_resp, b_rdata,
      output mem_read, mem_write, mem_address, mem_wdata,
      input  mem_resp, mem_rdata
   );

   modport master (
      output a_read, a_write, a_address, a_wdata,
      input  a_resp, a_rdata,
      output b_read, b_write, b_address, b_wdata,
      input  b_resp, b_rdata,
      input  mem_read, mem_write, mem_address, mem_wdata,
      output mem_resp, mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter: latches the winning request and holds it on memory until mem_resp.
// Tie-break is fixed B priority unless MEM_ARB_ROUND_ROBIN_EN is defined (then round-robin on last_grant).
module mem_arbiter (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_A = 2'd1,
      SERVE_B = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        last_grant_q, last_grant_d;

   logic        a_req, b_req, grant_b;

   always_comb begin
      a_req = bus.a_read | bus.a_write;
      b_req = bus.b_read | bus.b_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      // On a tie the port not granted last time wins.
      grant_b = b_req & (~a_req | ~last_grant_q);
`else
      grant_b = b_req;
`endif
   end

   always_comb begin
      state_d         = state_q;
      rd_d            = rd_q;
      wr_d            = wr_q;
      addr_d          = addr_q;
      wdata_d         = wdata_q;
      last_grant_d    = last_grant_q;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_address = 16'h0000;
      bus.mem_wdata   = 16'h0000;
      bus.a_resp      = 1'b0;
      bus.a_rdata     = 16'h0000;
      bus.b_resp      = 1'b0;
      bus.b_rdata     = 16'h0000;

      case (state_q)
         IDLE: begin
            if (a_req | b_req) begin
               last_grant_d = grant_b;
               // Both strobes high on one port is treated as a write.
               if (grant_b) begin
                  state_d = SERVE_B;
                  wr_d    = bus.b_write;
                  rd_d    = bus.b_read & ~bus.b_write;
                  addr_d  = bus.b_address;
                  wdata_d = bus.b_wdata;
               end else begin
                  state_d = SERVE_A;
                  wr_d    = bus.a_write;
                  rd_d    = bus.a_read & ~bus.a_write;
                  addr_d  = bus.a_address;
                  wdata_d = bus.a_wdata;
               end
            end
         end
         SERVE_A: begin
            bus.mem_read    = rd_q;
            bus.mem_write   = wr_q;
            bus.mem_address = addr_q;
            bus.mem_wdata   = wdata_q;
            if (bus.mem_resp) begin
               bus.a_resp  = 1'b1;
               bus.a_rdata = bus.mem_rdata;
               state_d     = IDLE;
            end
         end
         SERVE_B: begin
            bus.mem_read    = rd_q;
            bus.mem_write   = wr_q;
            bus.mem_address = addr_q;
            bus.mem_wdata   = wdata_q;
            if (bus.mem_resp) begin
               bus.b_resp  = 1'b1;
               bus.b_rdata = bus.mem_rdata;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         addr_q       <= 16'h0000;
         wdata_q      <= 16'h0000;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         rd_q         <= rd_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model of the arbiter (honours MEM_ARB_ROUND_ROBIN_EN like the design).
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Model: the transaction currently held on memory (owner -1 = none, 0 = A, 1 = B).
   int          owner;
   int          m_last;
   logic        m_rd, m_wr;
   logic [15:0] m_addr, m_wd;
   bit          check_en = 1'b0;

   logic [33:0] obs_mem;
   logic [16:0] obs_a, obs_b;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: inputs are already set; sample outputs mid-cycle, compare, advance the model.
   task automatic step();
      logic [33:0] e_mem;
      logic [16:0] e_a, e_b;
      bit          ra, rb;
      int          win;
      #3;
      obs_mem = {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata};
      obs_a   = {bus.a_resp, bus.a_rdata};
      obs_b   = {bus.b_resp, bus.b_rdata};
      e_mem = '0;
      e_a   = '0;
      e_b   = '0;
      if (owner >= 0) begin
         e_mem = {m_rd, m_wr, m_addr, m_wd};
         if (bus.mem_resp) begin
            if (owner == 0) e_a = {1'b1, bus.mem_rdata};
            else            e_b = {1'b1, bus.mem_rdata};
         end
      end
      if (check_en) begin
         chk("mem", obs_mem, e_mem);
         chk("port_a", obs_a, e_a);
         chk("port_b", obs_b, e_b);
      end
      if (reset) begin
         owner = -1; m_last = 1; m_rd = 0; m_wr = 0; m_addr = 0; m_wd = 0;
         check_en = 1'b1;
      end else if (owner >= 0) begin
         if (bus.mem_resp) owner = -1;
      end else begin
         ra = bus.a_read | bus.a_write;
         rb = bus.b_read | bus.b_write;
         if (ra || rb) begin
            if (ra && rb) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
               win = (m_last == 1) ? 0 : 1;
`else
               win = 1;
`endif
            end else begin
               win = rb ? 1 : 0;
            end
            if (win == 0) begin
               m_wr = bus.a_write; m_rd = bus.a_read & ~bus.a_write;
               m_addr = bus.a_address; m_wd = bus.a_wdata;
            end else begin
               m_wr = bus.b_write; m_rd = bus.b_read & ~bus.b_write;
               m_addr = bus.b_address; m_wd = bus.b_wdata;
            end
            m_last = win;
            owner  = win;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.a_read = 0; bus.a_write = 0; bus.a_address = 0; bus.a_wdata = 0;
      bus.b_read = 0; bus.b_write = 0; bus.b_address = 0; bus.b_wdata = 0;
      bus.mem_resp = 0; bus.mem_rdata = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   logic [33:0] first_op;
   bit          first_seen;
   int          na, nb, gidx, a_idx;

   initial begin
      owner = -1; m_last = 1; m_rd = 0; m_wr = 0; m_addr = 0; m_wd = 0;
      clear_inputs();
      reset = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // Reset state: everything quiet with no requests.
      step();
      chk("reset_mem", obs_mem, 34'h0);
      chk("reset_a", obs_a, 17'h0);
      chk("reset_b", obs_b, 17'h0);

      // Single A read, memory latency 2.
      bus.a_read = 1; bus.a_address = 16'h1234;
      step();
      step();
      chk("a_rd_c1", obs_mem[33:16], {1'b1, 1'b0, 16'h1234});
      step();
      bus.mem_resp = 1; bus.mem_rdata = 16'hBEEF;
      step();
      chk("a_rd_resp", obs_a, {1'b1, 16'hBEEF});
      chk("a_rd_bq", obs_b, 17'h0);
      bus.a_read = 0; bus.mem_resp = 0;
      step();
      chk("a_rd_dead", obs_mem, 34'h0);

      // Simultaneous requests, memory answers immediately.
      do_reset();
      bus.a_read = 1; bus.a_address = 16'h0010;
      bus.b_write = 1; bus.b_address = 16'h0020; bus.b_wdata = 16'h5A5A;
      bus.mem_resp = 1; bus.mem_rdata = 16'h1357;
      first_seen = 0; first_op = '0; na = 0; nb = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!first_seen && (obs_mem[33] || obs_mem[32])) begin
            first_seen = 1; first_op = obs_mem;
         end
         if (obs_a[16]) begin na++; bus.a_read = 0; end
         if (obs_b[16]) begin nb++; bus.b_write = 0; end
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("tie_first", first_op[33:16], {1'b1, 1'b0, 16'h0010});
`else
      chk("tie_first", first_op[33:16], {1'b0, 1'b1, 16'h0020});
`endif
      chk("tie_a_cnt", na, 1);
      chk("tie_b_cnt", nb, 1);

      // Latched request: B address/data change after grant, latency 3.
      do_reset();
      bus.b_write = 1; bus.b_address = 16'h0100; bus.b_wdata = 16'h1111;
      step();
      step();
      bus.b_address = 16'hFFFF; bus.b_wdata = 16'hFFFF;
      step();
      chk("latch_c2", obs_mem, {1'b0, 1'b1, 16'h0100, 16'h1111});
      step();
      chk("latch_c3", obs_mem, {1'b0, 1'b1, 16'h0100, 16'h1111});
      bus.mem_resp = 1; bus.mem_rdata = 16'h2222;
      step();
      chk("latch_c4", obs_mem, {1'b0, 1'b1, 16'h0100, 16'h1111});
      chk("latch_resp", obs_b, {1'b1, 16'h2222});
      bus.b_write = 0; bus.mem_resp = 0;
      step();

      // Starvation / fairness: B continuous, A joins one cycle later.
      do_reset();
      bus.b_read = 1; bus.b_address = 16'h0200; bus.a_address = 16'h0210;
      bus.mem_resp = 1; bus.mem_rdata = 16'h00AA;
      gidx = 0; a_idx = 0; na = 0;
      for (int i = 0; i < 16; i++) begin
         if (i == 1) bus.a_read = 1;
         step();
         if (obs_b[16]) gidx++;
         if (obs_a[16]) begin gidx++; a_idx = gidx; bus.a_read = 0; end
      end
      bus.b_read = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (obs_a[16]) begin na++; bus.a_read = 0; end
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      chk("starve_a_idx", a_idx, 2);
      chk("starve_a_late", na, 0);
`else
      chk("starve_a_idx", a_idx, 0);
      chk("starve_a_late", na, 1);
`endif

      // Reset while serving A, then a late mem_resp.
      do_reset();
      bus.a_read = 1; bus.a_address = 16'h0300;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0; bus.a_read = 0; bus.mem_resp = 1; bus.mem_rdata = 16'h7777;
      step();
      chk("rst_mid_mem", obs_mem, 34'h0);
      chk("rst_mid_a", obs_a, 17'h0);
      step();
      chk("rst_late_a", obs_a, 17'h0);
      bus.mem_resp = 0;

      // Both strobes on A: treated as a write.
      do_reset();
      bus.a_read = 1; bus.a_write = 1; bus.a_address = 16'h0040; bus.a_wdata = 16'h0001;
      step();
      bus.mem_resp = 1; bus.mem_rdata = 16'h4321;
      step();
      chk("illegal_op", obs_mem, {1'b0, 1'b1, 16'h0040, 16'h0001});
      chk("illegal_resp", obs_a[16], 1'b1);
      bus.a_read = 0; bus.a_write = 0; bus.mem_resp = 0;
      step();

      // Random traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) {bus.a_write, bus.a_read} = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) {bus.b_write, bus.b_read} = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) bus.a_address = 16'($urandom);
         if ($urandom_range(0, 2) == 0) bus.b_address = 16'($urandom);
         bus.a_wdata   = 16'($urandom);
         bus.b_wdata   = 16'($urandom);
         bus.mem_resp  = ($urandom_range(0, 2) == 0);
         bus.mem_rdata = 16'($urandom);
         reset = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
